// File: rtl/prvp_spi_slave_pkg.sv
// Shared definitions for the SPI slave command sequencer: command codes,
// frame states and shifter word-length constants.
package prvp_spi_slave_pkg;

  localparam logic [7:0] CMD_WREG0 = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WREG1 = 8'h11;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_W,
    ST_DATA_W,
    ST_ADDR_R,
    ST_DUMMY,
    ST_READ,
    ST_REG,
    ST_IGNORE
  } state_e;

  // Word lengths are expressed as (sclk cycles - 1), as the shifter expects.
  localparam logic [7:0] LEN_WORD32_SER  = 8'd31;
  localparam logic [7:0] LEN_WORD32_QUAD = 8'd7;
  localparam logic [7:0] LEN_BYTE8_SER   = 8'd7;
  localparam logic [7:0] LEN_BYTE8_QUAD  = 8'd1;

  function automatic logic [7:0] word32_len(input logic quad);
    return quad ? LEN_WORD32_QUAD : LEN_WORD32_SER;
  endfunction

  function automatic logic [7:0] byte8_len(input logic quad);
    return quad ? LEN_BYTE8_QUAD : LEN_BYTE8_SER;
  endfunction

endpackage

// File: rtl/prvp_spi_slave_cmd_ctrl_cfg_regs.sv
// Persistent configuration (quad mode, dummy-cycle count). Only the global
// reset clears these, so they survive chip-select frame boundaries.
module prvp_spi_slave_cmd_ctrl_cfg_regs #(
  parameter logic [7:0] DUMMY_RST = 8'd32
) (
  input  logic       clk,
  input  logic       rstnn,
  input  logic       quad_we_i,
  input  logic       quad_i,
  input  logic       dummy_we_i,
  input  logic [7:0] dummy_i,
  output logic       en_quad_o,
  output logic [7:0] dummy_o
);

  logic       en_quad_q;
  logic [7:0] dummy_q;

  // Configuration registers, written from the REG state of the sequencer.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      en_quad_q <= 1'b0;
      dummy_q   <= DUMMY_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (quad_we_i)  en_quad_q <= quad_i;
      if (dummy_we_i) dummy_q   <= dummy_i;
    end
  end

  assign en_quad_o = en_quad_q;
  assign dummy_o   = dummy_q;

endmodule

// File: rtl/prvp_spi_slave_cmd_ctrl.sv
// Command/address/data sequencer behind the SPI slave rx shifter. Walks a
// frame through CMD -> ADDR -> (DUMMY) -> DATA, reprograms the shifter word
// length as it goes, and emits write strobes, read requests and tx start.
module prvp_spi_slave_cmd_ctrl
  import prvp_spi_slave_pkg::*;
#(
  parameter logic [7:0]  DUMMY_RST = 8'd32,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        rstnn,
  input  logic        cs,
  input  logic [31:0] rx_data,
  input  logic        rx_data_ready,
  output logic [7:0]  rx_counter,
  output logic        rx_counter_upd,
  output logic        en_quad,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_next,
  output logic        tx_start
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic        reg_sel_q;   // 1: WREG1 (dummy), 0: WREG0 (quad)
  logic        wr_valid_q;
  logic        rd_req_q;
  logic        tx_start_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;

  logic        quad_we;
  logic        dummy_we;
  logic [7:0]  dummy;

  prvp_spi_slave_cmd_ctrl_cfg_regs #(
    .DUMMY_RST (DUMMY_RST)
  ) u_cfg_regs (
    .clk        (clk),
    .rstnn      (rstnn),
    .quad_we_i  (quad_we),
    .quad_i     (rx_data[0]),
    .dummy_we_i (dummy_we),
    .dummy_i    (rx_data[7:0]),
    .en_quad_o  (en_quad),
    .dummy_o    (dummy)
  );

  // Next word length for the shifter, raised in the same cycle as the word
  // strobe so the shifter keeps clocking without a gap.
  always_comb begin
    // NOTE: every output of this block gets a default first; without it a
    // path that skips an assignment would infer a latch.
    rx_counter     = '0;
    rx_counter_upd = 1'b0;
    quad_we        = 1'b0;
    dummy_we       = 1'b0;
    if (rx_data_ready) begin
      case (state_q)
        ST_CMD: begin
          case (rx_data[7:0])
            CMD_WRITE, CMD_READ: begin
              rx_counter_upd = 1'b1;
              rx_counter     = word32_len(en_quad);
            end
            CMD_WREG0, CMD_WREG1: begin
              rx_counter_upd = 1'b1;
              rx_counter     = byte8_len(en_quad);
            end
            default: ;
          endcase
        end
        ST_ADDR_W, ST_DATA_W: begin
          rx_counter_upd = 1'b1;
          rx_counter     = word32_len(en_quad);
        end
        ST_ADDR_R: begin
          if (dummy != 8'd0) begin
            rx_counter_upd = 1'b1;
            rx_counter     = dummy - 8'd1;
          end
        end
        ST_REG: begin
          quad_we  = !reg_sel_q;
          dummy_we = reg_sel_q;
        end
        default: ;
      endcase
    end
  end

  // Frame FSM with registered strobes; chip select aborts the frame at once.
  // NOTE: cs is a second asynchronous clear here, so a deselect wipes the
  // frame and any pending strobe even when it lands on an active edge.
  always_ff @(posedge clk or negedge rstnn or posedge cs) begin
    if (!rstnn) begin
      state_q    <= ST_CMD;
      addr_q     <= '0;
      reg_sel_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      tx_start_q <= 1'b0;
    end else if (cs) begin
      state_q    <= ST_CMD;
      addr_q     <= '0;
      reg_sel_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        ST_CMD: begin
          if (rx_data_ready) begin
            case (rx_data[7:0])
              CMD_WRITE: state_q <= ST_ADDR_W;
              CMD_READ:  state_q <= ST_ADDR_R;
              CMD_WREG0, CMD_WREG1: begin
                state_q   <= ST_REG;
                reg_sel_q <= (rx_data[7:0] == CMD_WREG1);
              end
              default:   state_q <= ST_IGNORE;
            endcase
          end
        end
        ST_ADDR_W: begin
          if (rx_data_ready) begin
            addr_q  <= rx_data;
            state_q <= ST_DATA_W;
          end
        end
        ST_DATA_W: begin
          if (rx_data_ready) begin
            wr_valid_q <= 1'b1;
            addr_q     <= addr_q + 32'(ADDR_STEP);
          end
        end
        ST_ADDR_R: begin
          if (rx_data_ready) begin
            addr_q   <= rx_data;
            rd_req_q <= 1'b1;
            if (dummy != 8'd0) begin
              state_q <= ST_DUMMY;
            end else begin
              state_q    <= ST_READ;
              tx_start_q <= 1'b1;
            end
          end
        end
        ST_DUMMY: begin
          if (rx_data_ready) begin
            state_q    <= ST_READ;
            tx_start_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (rd_next) begin
            addr_q   <= addr_q + 32'(ADDR_STEP);
            rd_req_q <= 1'b1;
          end
        end
        ST_REG: begin
          if (rx_data_ready) state_q <= ST_IGNORE;
        end
        default: ;
      endcase
    end
  end

  // Write payload captured alongside the write strobe.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (state_q == ST_DATA_W && rx_data_ready && !cs) begin
      wr_addr_q <= addr_q;
      wr_data_q <= rx_data;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = addr_q;
  assign tx_start = tx_start_q;

endmodule

// File: doc/prvp_spi_slave_cmd_ctrl.md
Name: prvp_spi_slave_cmd_ctrl

Overview:
Command/address/data sequencer directly downstream of the SPI slave receive shifter. It consumes the shifter's word strobe (rx_data, rx_data_ready) and reprograms the shifter's word length (rx_counter, rx_counter_upd) as a frame advances: CMD, ADDR, DUMMY, DATA. It turns frames into word-write strobes, read-address requests and a tx start pulse, and holds the persistent quad-mode and dummy-cycle configuration.

Parameters:
DUMMY_RST, 8'd32, reset value of dummy-cycle count register
ADDR_STEP, 4, byte increment of address per data word

Ports:
clk  in  1  SPI clock (sclk domain)
rstnn  in  1  asynchronous active-low reset; clears everything
cs  in  1  chip select, active-high = deselected; asynchronous frame clear
rx_data  in  32  word from rx shifter
rx_data_ready  in  1  word-complete strobe from rx shifter
rx_counter  out  8  word length minus 1, in sclk cycles
rx_counter_upd  out  1  load rx_counter into shifter and keep it running
en_quad  out  1  quad mode; drives shifter and tx
wr_valid  out  1  one-cycle write strobe
wr_addr  out  32  write word address
wr_data  out  32  write word data
rd_req  out  1  one-cycle read request
rd_addr  out  32  read word address
rd_next  in  1  tx finished a word; fetch next
tx_start  out  1  one-cycle pulse, tx begins read data phase

Behaviour:
- Reset (rstnn low): state=CMD, addr=0, en_quad=0, dummy=DUMMY_RST. All strobes are 0 and rx_counter=0.
- cs high asynchronously clears only state (to CMD), addr and the registered strobes. en_quad and dummy persist across frames.
- rx_counter/rx_counter_upd are combinational from state, rx_data_ready, rx_data and en_quad. upd asserts in the same cycle as rx_data_ready so the shifter never stalls.
- Lengths: WORD32 = en_quad?7:31; BYTE8 = en_quad?1:7; DUMMY = dummy-1.
- CMD: first rx_data_ready. Command is rx_data[7:0].
  - 0x02 WRITE: go to ADDR_W, upd WORD32.
  - 0x0B READ: go to ADDR_R, upd WORD32.
  - 0x01 WREG0 or 0x11 WREG1: go to REG, upd BYTE8.
  - Any other command: go to IGNORE, no upd (shifter halts).
- ADDR_W: on ready, addr<=rx_data; go to DATA_W; upd WORD32.
- DATA_W: each ready gives a registered wr_valid=1 next cycle with wr_addr=addr, wr_data=rx_data. Then addr<=addr+ADDR_STEP, wrapping mod 2^32. upd WORD32 on every word. A partial word at cs deassert is discarded.
- ADDR_R: on ready, addr<=rx_data and rd_req pulses next cycle with rd_addr=rx_data.
  - If dummy!=0: go to DUMMY, upd DUMMY.
  - If dummy==0: go to READ, tx_start pulses, no upd.
- DUMMY: on ready, go to READ, tx_start pulses, no upd.
- READ: each rd_next gives addr<=addr+ADDR_STEP and rd_req pulses next cycle with the new addr. rd_next is ignored in all other states.
- REG: on ready, WREG0 sets en_quad<=rx_data[0] and WREG1 sets dummy<=rx_data[7:0]. Then go to IGNORE. The new en_quad applies from the next cycle.
- IGNORE: all inputs ignored until cs or rstnn.
- Simultaneous cs assert with any strobe: cs wins, so no strobe is issued.

Decomposition:
- prvp_spi_slave_pkg holds:
  - command code constants (0x01, 0x02, 0x0B, 0x11)
  - state enum (CMD, ADDR_W, DATA_W, ADDR_R, DUMMY, READ, REG, IGNORE)
  - WORD32/BYTE8 serial and quad length constants
- Optional sub-module prvp_spi_slave_cfg_regs holds en_quad and dummy on rstnn only. All other logic is inline.

Test Plan:
- Serial WRITE: cmd 0x02, addr 0x0000_1000, data 0xDEADBEEF and 0x12345678 -> wr_valid twice, at (0x1000, 0xDEADBEEF) then (0x1004, 0x12345678). rx_counter=31 on each upd.
- WREG0 with 0x01 then a new frame WRITE -> en_quad=1; the address upd uses rx_counter=7; wr_addr increments by 4 per word.
- READ with dummy=32: cmd 0x0B, addr 0xFFFF_FFFC -> rd_req rd_addr=0xFFFFFFFC; DUMMY upd rx_counter=31; tx_start one cycle after dummy ready; rd_next -> rd_req rd_addr=0x00000000 (wrap).
- WREG1 with 0x00, then READ -> no DUMMY state; tx_start one cycle after address ready.
- Unknown cmd 0xA5 -> no upd, no strobes for 100 cycles; next frame after cs toggle decodes normally.
- cs asserted mid DATA_W after 20 bits -> no wr_valid, state=CMD. en_quad/dummy retain values; rstnn low clears them to 0/32.
